fetch_queue: RTL
================

# fetch_queue

Parametrised instruction-fetch front end that replaces the single-entry fetch/IMEM path of the first pipeline stage with a decoupled, multi-request design. It keeps up to DEPTH instruction-cache requests in flight and buffers returned words in a DEPTH-entry FIFO with a per-entry PC. Decode drains the FIFO through a valid/ready handshake. A redirect from the writeback/branch stage flushes the FIFO and silently discards stale in-flight responses.

## Interface
- XLEN, 32, address/instruction width
- DEPTH, 4, FIFO entries and maximum in-flight requests; power of two, ≥2
- RESET_PC, 32'h0000_2000, fetch address after reset
- NOP, 32'h0000_0013, value driven on inst when the FIFO is empty
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  take redirect_pc as the new fetch address and flush
- redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored and treated as 0
- icache_req_valid  out  1  request valid
- icache_req_ready  in  1  cache accepts the request
- icache_addr  out  XLEN  request address; equals fetch_pc
- icache_resp_valid  in  1  response word valid; responses return in request order
- icache_resp_data  in  XLEN  response word
- inst_valid  out  1  FIFO head is valid
- inst_ready  in  1  decode consumes the head
- inst  out  XLEN  head instruction; NOP when empty
- inst_pc  out  XLEN  PC of the head instruction; 0 when empty
- occupancy  out  $clog2(DEPTH+1)  number of FIFO entries

## Operation
- State:
  - fetch_pc: next request address.
  - resp_pc: PC of the next non-stale response.
  - outstanding: in-flight requests, counter 0..DEPTH.
  - drop_cnt: stale responses still to discard, 0..DEPTH.
  - FIFO: DEPTH entries of {pc, inst}, with rd/wr pointers that wrap modulo DEPTH.
- Issue rule: icache_req_valid = !reset && !redirect_valid && (occupancy + outstanding < DEPTH).
  - req_fire = icache_req_valid && icache_req_ready.
  - On req_fire, fetch_pc += 4. Arithmetic is modulo 2^XLEN; wrap from FFFF_FFFC to 0 is legal.
- Response handling when icache_resp_valid is high:
  - outstanding decrements.
  - If drop_cnt>0 or redirect_valid, the word is discarded and drop_cnt decrements (when >0).
  - Otherwise {resp_pc, data} is pushed and resp_pc += 4.
- Pop: pop_fire = inst_valid && inst_ready && !redirect_valid. Push and pop may occur in the same cycle; occupancy is then unchanged.
- The credit rule guarantees no push into a full FIFO. A response arriving when outstanding==0 is a protocol error; it is ignored and outstanding stays 0.
- Redirect, on the edge following redirect_valid high:
  - FIFO cleared (occupancy 0, pointers 0).
  - fetch_pc and resp_pc ← redirect_pc.
  - drop_cnt ← outstanding − resp_valid_this_cycle, counting all still-in-flight requests as stale.
  - outstanding ← same value.
  - Pop and issue are suppressed in the redirect cycle.
- Back-to-back redirects: the last one wins. Each recomputes drop_cnt from the current outstanding value.
- Reset overrides redirect and all other inputs. It clears the FIFO, outstanding and drop_cnt, and sets fetch_pc = resp_pc = RESET_PC. In-flight responses arriving after reset deasserts are the cache's responsibility; the cache must be reset together with this block.

## Timing
- Reset values:
  - icache_req_valid=0.
  - icache_addr=RESET_PC.
  - inst_valid=0, inst=NOP, inst_pc=0, occupancy=0.
- icache_req_valid, icache_addr, inst_valid, inst, inst_pc and occupancy are functions of registered state only. The exception is the redirect_valid gating of icache_req_valid.
- Latency:
  - Request accepted at cycle t, response at t+k (k≥1), inst_valid at t+k+1. There is no response-to-output bypass.
  - Minimum latency is 2 cycles.
- Throughput: one instruction per cycle in steady state when k ≤ DEPTH−1 and inst_ready is held high.
- After a redirect in cycle r:
  - The first request to redirect_pc issues at r+1.
  - inst_valid stays low at least through r+2.

## Test plan
- Reset then stream, cache ready always, k=1, inst_ready=1 → requests to 2000, 2004, 2008…; first inst_valid 2 cycles after the first accept; inst_pc increments by 4 every cycle.
- inst_ready=0 with DEPTH=4 → exactly 4 requests accepted, icache_req_valid then low, occupancy=4. Raising inst_ready for one cycle → one pop and exactly one new request.
- Three requests in flight, FIFO holding 1, then redirect to 3000 → FIFO empties; the next 3 responses (data AAAA_0001..3) never appear on inst; the first word delivered carries inst_pc=3000.
- A redirect coinciding with a response and inst_ready=1 → that response is dropped, no pop occurs, and drop_cnt equals outstanding−1.
- fetch_pc at FFFF_FFF8 → requests FFFF_FFF8, FFFF_FFFC, 0000_0000 with matching inst_pc on delivery.
- Reset asserted with 2 entries buffered and 2 in flight → all outputs return to reset values on the next edge; after release, fetching restarts at 2000.

Source files
------------

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: keeps up to DEPTH cache requests in flight and buffers
// returned words with their PCs in a DEPTH-entry FIFO drained by decode. A redirect flushes the
// FIFO and marks every in-flight request as stale so its response is dropped.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_2000,
  parameter logic [XLEN-1:0] NOP      = 32'h0000_0013,
  localparam int unsigned    CW       = $clog2(DEPTH + 1),
  localparam int unsigned    PW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            icache_req_valid,
  input  logic            icache_req_ready,
  output logic [XLEN-1:0] icache_addr,
  input  logic            icache_resp_valid,
  input  logic [XLEN-1:0] icache_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [CW-1:0]   occupancy
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] mem_pc_q [DEPTH];
  logic [XLEN-1:0] mem_pc_d [DEPTH];
  logic [XLEN-1:0] mem_inst_q [DEPTH];
  logic [XLEN-1:0] mem_inst_d [DEPTH];

  logic            credit_ok;
  logic            req_fire;
  logic            resp_ok;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_base;

  // Buffered entries plus in-flight requests never exceed DEPTH, so a push never finds it full.
  assign credit_ok = ({1'b0, occ_q} + {1'b0, outstanding_q}) < (CW + 1)'(DEPTH);

  // Responses with nothing outstanding are protocol errors and are ignored entirely.
  assign resp_ok   = icache_resp_valid && (outstanding_q != '0);
  assign push      = resp_ok && (drop_cnt_q == '0) && !redirect_valid;
  assign req_fire  = icache_req_valid && icache_req_ready;
  assign pop       = inst_valid && inst_ready && !redirect_valid;

  assign redirect_base = redirect_pc & ~XLEN'(3);

  // Outputs depend on registered state; only the request is also gated by reset/redirect.
  always_comb begin
    icache_req_valid = !reset && !redirect_valid && credit_ok;
    icache_addr      = fetch_pc_q;
    occupancy        = occ_q;
    inst_valid       = (occ_q != '0);
    inst             = NOP;
    inst_pc          = '0;
    if (inst_valid) begin
      inst    = mem_inst_q[rd_ptr_q];
      inst_pc = mem_pc_q[rd_ptr_q];
    end
  end

  // Next-state: redirect flush, otherwise issue / response / pop bookkeeping.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    occ_d         = occ_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mem_pc_d      = mem_pc_q;
    mem_inst_d    = mem_inst_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_base;
      resp_pc_d     = redirect_base;
      // Everything still in flight after this cycle's response is stale.
      outstanding_d = outstanding_q - CW'(resp_ok);
      drop_cnt_d    = outstanding_q - CW'(resp_ok);
      occ_d         = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_ok);
      if (resp_ok && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        mem_pc_d[wr_ptr_q]   = resp_pc_q;
        mem_inst_d[wr_ptr_q] = icache_resp_data;
        wr_ptr_d             = wr_ptr_q + PW'(1);
        resp_pc_d            = resp_pc_q + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      occ_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      occ_q         <= occ_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // FIFO storage; contents are qualified by occupancy so they need no reset.
  always_ff @(posedge clk) begin
    mem_pc_q   <= mem_pc_d;
    mem_inst_q <= mem_inst_d;
  end

endmodule
